// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-channel hour/minute alarm controller with snooze, timeout and missed log
//
// Ports:
//   count          clock, all state updates on the rising edge
//   reset_in_n     asynchronous active-low reset
//   tick_min       one-cycle strobe marking a new minute on input_hours/input_minutes
//   input_hours    current hours, 0..23
//   input_minutes  current minutes, 0..59
//   wr_en          write one alarm channel (wr_idx, wr_hours, wr_minutes, wr_arm)
//   ring_stop      dismiss the current event
//   snooze_req     snooze the current event
//   missed_clr     clear the missed log
//   ring           alarm is sounding
//   snoozed        current event is waiting out a snooze
//   active_idx     channel owning the current event
//   snooze_left    minute ticks left in the snooze, 0 when not snoozed
//   armed          per-channel arm bits
//   missed         sticky per-channel missed/timed-out flags
//   wr_err         one-cycle pulse after a rejected write
module alarm_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int MAX_SNOOZE   = 3,
  parameter int RING_TIMEOUT = 10,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  count,
  input  logic                  reset_in_n,
  input  logic                  tick_min,
  input  logic [5:0]            input_hours,
  input  logic [5:0]            input_minutes,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [5:0]            wr_hours,
  input  logic [5:0]            wr_minutes,
  input  logic                  wr_arm,
  input  logic                  ring_stop,
  input  logic                  snooze_req,
  input  logic                  missed_clr,
  output logic                  ring,
  output logic                  snoozed,
  output logic [IDX_W-1:0]      active_idx,
  output logic [7:0]            snooze_left,
  output logic [NUM_ALARMS-1:0] armed,
  output logic [NUM_ALARMS-1:0] missed,
  output logic                  wr_err
);

  localparam logic [7:0] SNOOZE_LEN   = 8'(SNOOZE_MIN);
  localparam logic [3:0] SNOOZE_LIMIT = 4'(MAX_SNOOZE);
  localparam logic [7:0] TIMEOUT_LAST = 8'(RING_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RINGING,
    ST_SNOOZED
  } state_t;

  state_t state, state_nx;

  // Alarm time per channel packed as {hours, minutes}, same layout as the time inputs.
  logic [11:0] alarm_time [NUM_ALARMS];

  logic [3:0]            snooze_uses, uses_nx;
  logic [7:0]            ring_ticks, ticks_nx;
  logic [7:0]            left_nx;
  logic [IDX_W-1:0]      idx_nx;
  logic [NUM_ALARMS-1:0] hit;
  logic [NUM_ALARMS-1:0] first_oh;
  logic [IDX_W-1:0]      first_idx;
  logic [NUM_ALARMS-1:0] miss_set;
  logic [NUM_ALARMS-1:0] missed_nx;
  logic                  idx_ok;
  logic                  wr_ok;
  logic                  cancel;

  assign idx_ok = (32'(wr_idx) < 32'(NUM_ALARMS));
  assign wr_ok  = wr_en && (wr_hours <= 6'd23) && (wr_minutes <= 6'd59) && idx_ok;

  // Disarming the owning channel ends the event quietly, whatever else happens that cycle.
  assign cancel = wr_ok && !wr_arm && (wr_idx == active_idx) && (state != ST_IDLE);

  // Matches use the stored contents, so a same-cycle write only affects later ticks.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      hit[i] = tick_min && armed[i] && (alarm_time[i] == {input_hours, input_minutes});
    end
  end

  // Lowest-index hit wins ownership of a new event.
  always_comb begin
    first_idx = '0;
    first_oh  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        first_idx   = IDX_W'(i);
        first_oh    = '0;
        first_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = active_idx;
    uses_nx  = snooze_uses;
    ticks_nx = ring_ticks;
    left_nx  = snooze_left;
    miss_set = '0;

    case (state)
      ST_IDLE: begin
        if (|hit) begin
          state_nx = ST_RINGING;
          idx_nx   = first_idx;
          uses_nx  = '0;
          ticks_nx = '0;
          miss_set = hit & ~first_oh;
        end
      end

      ST_RINGING: begin
        miss_set = hit;
        if (cancel || ring_stop) begin
          state_nx = ST_IDLE;
        end else if (snooze_req) begin
          if (snooze_uses < SNOOZE_LIMIT) begin
            state_nx = ST_SNOOZED;
            left_nx  = SNOOZE_LEN;
            uses_nx  = snooze_uses + 4'd1;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (tick_min) begin
          if (ring_ticks == TIMEOUT_LAST) begin
            state_nx             = ST_IDLE;
            miss_set[active_idx] = 1'b1;
          end else begin
            ticks_nx = ring_ticks + 8'd1;
          end
        end
      end

      ST_SNOOZED: begin
        miss_set = hit;
        if (cancel || ring_stop) begin
          state_nx = ST_IDLE;
        end else if (tick_min) begin
          if (snooze_left == 8'd1) begin
            state_nx = ST_RINGING;
            ticks_nx = '0;
          end else begin
            left_nx = snooze_left - 8'd1;
          end
        end
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (state_nx != ST_SNOOZED) begin
      left_nx = '0;
    end

    // A fresh miss in the same cycle outranks the clear.
    missed_nx = (missed & ~{NUM_ALARMS{missed_clr}}) | miss_set;
  end

  always_ff @(posedge count or negedge reset_in_n) begin
    if (!reset_in_n) begin
      state       <= ST_IDLE;
      active_idx  <= '0;
      snooze_uses <= '0;
      ring_ticks  <= '0;
      snooze_left <= '0;
      ring        <= 1'b0;
      snoozed     <= 1'b0;
      missed      <= '0;
      wr_err      <= 1'b0;
      armed       <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_time[i] <= '0;
      end
    end else begin
      state       <= state_nx;
      active_idx  <= idx_nx;
      snooze_uses <= uses_nx;
      ring_ticks  <= ticks_nx;
      snooze_left <= left_nx;
      ring        <= (state_nx == ST_RINGING);
      snoozed     <= (state_nx == ST_SNOOZED);
      missed      <= missed_nx;
      wr_err      <= wr_en && !wr_ok;
      if (wr_ok) begin
        alarm_time[wr_idx] <= {wr_hours, wr_minutes};
        armed[wr_idx]      <= wr_arm;
      end
    end
  end

endmodule

// File: tb/tb_alarm_bank.sv
// tb/tb_alarm_bank.sv - randomized self-checking bench for alarm_bank against a minute-level model
module tb_alarm_bank;
  localparam int N    = 4;
  localparam int SNZ  = 5;
  localparam int MAXS = 3;
  localparam int TMO  = 10;
  localparam int IW   = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;

  logic          count = 1'b0;
  logic          reset_in_n = 1'b0;
  logic          tick_min = 1'b0;
  logic [5:0]    input_hours = '0;
  logic [5:0]    input_minutes = '0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_idx = '0;
  logic [5:0]    wr_hours = '0;
  logic [5:0]    wr_minutes = '0;
  logic          wr_arm = 1'b0;
  logic          ring_stop = 1'b0;
  logic          snooze_req = 1'b0;
  logic          missed_clr = 1'b0;
  logic          ring;
  logic          snoozed;
  logic [IW-1:0] active_idx;
  logic [7:0]    snooze_left;
  logic [N-1:0]  armed;
  logic [N-1:0]  missed;
  logic          wr_err;

  alarm_bank #(
    .NUM_ALARMS  (N),
    .SNOOZE_MIN  (SNZ),
    .MAX_SNOOZE  (MAXS),
    .RING_TIMEOUT(TMO)
  ) dut (
    .count        (count),
    .reset_in_n   (reset_in_n),
    .tick_min     (tick_min),
    .input_hours  (input_hours),
    .input_minutes(input_minutes),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_hours     (wr_hours),
    .wr_minutes   (wr_minutes),
    .wr_arm       (wr_arm),
    .ring_stop    (ring_stop),
    .snooze_req   (snooze_req),
    .missed_clr   (missed_clr),
    .ring         (ring),
    .snoozed      (snoozed),
    .active_idx   (active_idx),
    .snooze_left  (snooze_left),
    .armed        (armed),
    .missed       (missed),
    .wr_err       (wr_err)
  );

  always #5 count = ~count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: alarm times kept as minute-of-day numbers.
  int m_time [N];
  bit m_arm  [N];
  int m_state, m_active, m_uses, m_rung, m_left, m_missed;
  bit m_werr;
  int cur_min = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_time[i] = 0;
      m_arm[i]  = 1'b0;
    end
    m_state = M_IDLE; m_active = 0; m_uses = 0; m_rung = 0; m_left = 0;
    m_missed = 0; m_werr = 1'b0;
  endtask

  task automatic model_step();
    int now, hits, mset, low;
    bit ok, cancel;
    now  = int'(input_hours) * 60 + int'(input_minutes);
    hits = 0;
    if (tick_min)
      for (int i = 0; i < N; i++)
        if (m_arm[i] && m_time[i] == now) hits |= (1 << i);
    ok     = wr_en && wr_hours < 24 && wr_minutes < 60 && int'(wr_idx) < N;
    cancel = ok && !wr_arm && m_state != M_IDLE && int'(wr_idx) == m_active;
    mset   = 0;
    if (m_state == M_IDLE) begin
      if (hits != 0) begin
        low = 0;
        while (!hits[low]) low++;
        m_state = M_RING; m_active = low; m_uses = 0; m_rung = 0;
        mset = hits & ~(1 << low);
      end
    end else if (m_state == M_RING) begin
      mset = hits;
      if (cancel || ring_stop) m_state = M_IDLE;
      else if (snooze_req) begin
        if (m_uses < MAXS) begin
          m_state = M_SNZ; m_left = SNZ; m_uses++;
        end else m_state = M_IDLE;
      end else if (tick_min) begin
        m_rung++;
        if (m_rung == TMO) begin
          m_state = M_IDLE;
          mset |= (1 << m_active);
        end
      end
    end else begin
      mset = hits;
      if (cancel || ring_stop) m_state = M_IDLE;
      else if (tick_min) begin
        m_left--;
        if (m_left == 0) begin
          m_state = M_RING; m_rung = 0;
        end
      end
    end
    if (m_state != M_SNZ) m_left = 0;
    m_missed = (missed_clr ? 0 : m_missed) | mset;
    m_werr   = wr_en && !ok;
    if (ok) begin
      m_time[wr_idx] = int'(wr_hours) * 60 + int'(wr_minutes);
      m_arm[wr_idx]  = wr_arm;
    end
  endtask

  function automatic int arm_mask();
    int m = 0;
    for (int i = 0; i < N; i++) if (m_arm[i]) m |= (1 << i);
    return m;
  endfunction

  task automatic step(input string tag);
    model_step();
    @(posedge count);
    #1;
    check_eq({tag, "_ring"},    ring,        m_state == M_RING);
    check_eq({tag, "_snoozed"}, snoozed,     m_state == M_SNZ);
    check_eq({tag, "_idx"},     active_idx,  m_active);
    check_eq({tag, "_left"},    snooze_left, m_left);
    check_eq({tag, "_armed"},   armed,       arm_mask());
    check_eq({tag, "_missed"},  missed,      m_missed);
    check_eq({tag, "_wr_err"},  wr_err,      m_werr);
    wr_en = 1'b0; tick_min = 1'b0; ring_stop = 1'b0; snooze_req = 1'b0; missed_clr = 1'b0;
  endtask

  task automatic set_time(input int mins);
    cur_min       = mins % 1440;
    input_hours   = 6'(cur_min / 60);
    input_minutes = 6'(cur_min % 60);
  endtask

  task automatic tick_to(input int h, input int m, input string tag);
    set_time(h * 60 + m);
    tick_min = 1'b1;
    step(tag);
  endtask

  task automatic tick_next(input string tag);
    set_time(cur_min + 1);
    tick_min = 1'b1;
    step(tag);
  endtask

  task automatic do_write(input int idx, input int h, input int m, input bit arm, input string tag);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_hours = 6'(h); wr_minutes = 6'(m); wr_arm = arm;
    step(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ring"},    ring,        0);
    check_eq({tag, "_snoozed"}, snoozed,     0);
    check_eq({tag, "_idx"},     active_idx,  0);
    check_eq({tag, "_left"},    snooze_left, 0);
    check_eq({tag, "_armed"},   armed,       0);
    check_eq({tag, "_missed"},  missed,      0);
    check_eq({tag, "_wr_err"},  wr_err,      0);
  endtask

  initial begin
    int r, target;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge count);
    #1 reset_in_n = 1'b1;

    // Single alarm, dismiss, no re-ring within the minute.
    do_write(1, 7, 30, 1'b1, "tp1_wr");
    tick_to(7, 29, "tp1_t0");
    tick_to(7, 30, "tp1_t1");
    check_eq("tp1_ring_on", ring, 1);
    check_eq("tp1_active", active_idx, 1);
    ring_stop = 1'b1;
    step("tp1_stop");
    check_eq("tp1_ring_off", ring, 0);
    for (int k = 0; k < 3; k++) step("tp1_idle");
    tick_to(7, 31, "tp1_next");
    check_eq("tp1_no_rering", ring, 0);

    // Two channels on the same minute.
    do_write(0, 6, 0, 1'b1, "tp2_wr0");
    do_write(2, 6, 0, 1'b1, "tp2_wr2");
    tick_to(6, 0, "tp2_hit");
    check_eq("tp2_active", active_idx, 0);
    check_eq("tp2_missed", missed, 4'b0100);
    ring_stop = 1'b1;
    step("tp2_stop");
    missed_clr = 1'b1;
    step("tp2_clr");
    check_eq("tp2_missed_clr", missed, 0);

    // Snooze three times, fourth request dismisses.
    do_write(3, 8, 0, 1'b1, "tp3_wr");
    tick_to(8, 0, "tp3_hit");
    for (int s = 0; s < MAXS; s++) begin
      snooze_req = 1'b1;
      step("tp3_snz");
      check_eq("tp3_snoozed", snoozed, 1);
      check_eq("tp3_left", snooze_left, SNZ);
      for (int k = 0; k < SNZ; k++) tick_next("tp3_tick");
      check_eq("tp3_rering", ring, 1);
    end
    snooze_req = 1'b1;
    step("tp3_last");
    check_eq("tp3_dismissed", ring, 0);
    check_eq("tp3_not_snoozed", snoozed, 0);

    // Auto-timeout after RING_TIMEOUT ticks.
    do_write(3, 9, 0, 1'b1, "tp4_wr");
    tick_to(9, 0, "tp4_hit");
    for (int k = 1; k < TMO; k++) tick_next("tp4_tick");
    check_eq("tp4_still_ringing", ring, 1);
    tick_next("tp4_last");
    check_eq("tp4_timed_out", ring, 0);
    check_eq("tp4_missed", missed, 4'b1000);
    missed_clr = 1'b1;
    step("tp4_clr");

    // Rejected writes and disarm of the active channel.
    do_write(0, 24, 10, 1'b0, "tp5_badh");
    check_eq("tp5_err_h", wr_err, 1);
    check_eq("tp5_armed_h", armed, 4'b1111);
    step("tp5_gap");
    check_eq("tp5_err_pulse", wr_err, 0);
    do_write(1, 5, 60, 1'b0, "tp5_badm");
    check_eq("tp5_err_m", wr_err, 1);
    check_eq("tp5_armed_m", armed, 4'b1111);
    do_write(2, 10, 0, 1'b1, "tp5_wr2");
    tick_to(10, 0, "tp5_hit");
    check_eq("tp5_active", active_idx, 2);
    do_write(2, 10, 0, 1'b0, "tp5_disarm");
    check_eq("tp5_cancel", ring, 0);
    check_eq("tp5_missed_kept", missed, 0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 35) begin
        set_time(cur_min + 1);
        tick_min = 1'b1;
      end
      if ($urandom_range(0, 99) < 15) begin
        wr_en  = 1'b1;
        wr_idx = ($urandom_range(0, 3) == 0) ? IW'(m_active) : IW'($urandom_range(0, N - 1));
        target = (cur_min + $urandom_range(0, 6)) % 1440;
        wr_hours   = 6'(target / 60);
        wr_minutes = 6'(target % 60);
        if ($urandom_range(0, 9) == 0) wr_hours = 6'($urandom_range(24, 63));
        if ($urandom_range(0, 9) == 0) wr_minutes = 6'($urandom_range(60, 63));
        wr_arm = ($urandom_range(0, 3) != 0);
      end
      ring_stop  = ($urandom_range(0, 99) < 5);
      snooze_req = ($urandom_range(0, 99) < 12);
      missed_clr = ($urandom_range(0, 99) < 5);
      step("rnd");
    end

    // Reset while snoozed.
    ring_stop = 1'b1;
    step("tp6_stop");
    for (int i = 0; i < N; i++) do_write(i, 0, 0, 1'b0, "tp6_disarm");
    target = (cur_min + 2) % 1440;
    do_write(1, target / 60, target % 60, 1'b1, "tp6_wr");
    tick_next("tp6_t0");
    tick_next("tp6_t1");
    check_eq("tp6_ring", ring, 1);
    snooze_req = 1'b1;
    step("tp6_snz");
    check_eq("tp6_snoozed", snoozed, 1);
    #2 reset_in_n = 1'b0;
    #1;
    check_all_zero("tp6_async");
    model_reset();
    @(posedge count);
    #1 reset_in_n = 1'b1;
    tick_to(target / 60, target % 60, "tp6_after");
    check_eq("tp6_no_ring", ring, 0);
    check_eq("tp6_disarmed", armed, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
